life_controller: RTL and testbench

Sequencer for the 8x8 Game-of-Life cell array.
- Generates the one-cycle generation enable (gen_tick) from the system clock at a selectable rate.
- Loads seed patterns into the cells and supports run, pause and single-step.
- Counts generations and halts automatically when the board goes extinct or stops changing.
- Sits between the board-level user controls and the 64-cell array; it drives the array's advance enable and load/init inputs.

---
 rtl/life_pkg.sv | 30 +++
 rtl/tick_divider.sv | 56 +++++
 rtl/life_controller.sv | 163 ++++++++++++++++
 tb/tb_life_controller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and seed patterns for the 8x8 Game-of-Life sequencer.
package life_pkg;

  localparam int GRID = 64;

  // Sequencer state; the encoding is exported on the status port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Why the board stopped advancing; exported on the halt_reason port.
  typedef enum logic [1:0] {
    RSN_NONE    = 2'd0,
    RSN_EXTINCT = 2'd1,
    RSN_STABLE  = 2'd2
  } reason_t;

  // Seed patterns, bit index = row*8 + col with row 0 at the top.
  localparam logic [GRID-1:0] PATTERNS [4] = '{
    64'h0000_0000_1C00_0000,  // 0: blinker
    64'h0000_0000_0007_0402,  // 1: glider
    64'h0000_0018_1800_0000,  // 2: block
    64'h0000_0000_0000_0001   // 3: single cell
  };

endpackage

// File: rtl/tick_divider.sv
// Generation-rate divider: a BASE_DIV prescaler feeding a speed counter.
// tc is high for one clock every BASE_DIV*(speed+1) enabled clocks; the
// speed input is captured on clear and on every full-period wrap so a
// change never produces a runt period.
module tick_divider
  import life_pkg::*;
#(
  parameter int BASE_DIV = 1_562_500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       tc
);

  localparam int            PW      = $clog2(BASE_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(BASE_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_spd_cnt;
  logic [2:0]    r_spd_lat;
  logic          w_pre_end;
  logic          w_spd_end;

  assign w_pre_end = (r_pre == PRE_MAX);
  assign w_spd_end = (r_spd_cnt == r_spd_lat);
  assign tc        = en && w_pre_end && w_spd_end;

  // Prescale and speed counters; hold when not enabled, restart on clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= '0;
      r_spd_cnt <= '0;
      r_spd_lat <= '0;
    end else if (clr) begin
      r_pre     <= '0;
      r_spd_cnt <= '0;
      r_spd_lat <= speed;
    end else if (en) begin
      if (w_pre_end) begin
        r_pre <= '0;
        if (w_spd_end) begin
          r_spd_cnt <= '0;
          r_spd_lat <= speed;
        end else begin
          r_spd_cnt <= r_spd_cnt + 3'd1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/life_controller.sv
// Sequencer for the 8x8 Game-of-Life array: loads seeds, runs / pauses /
// single-steps the generation enable, counts generations and halts when
// the board dies out or stops changing. Every output is a flop.
module life_controller
  import life_pkg::*;
#(
  parameter int BASE_DIV = 1_562_500,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [1:0]       pattern_sel,
  input  logic             run,
  input  logic             step,
  input  logic [2:0]       speed,
  input  logic [GRID-1:0]  board,
  output logic             gen_tick,
  output logic             cell_load,
  output logic [GRID-1:0]  init_pattern,
  output logic [GEN_W-1:0] generation,
  output logic [2:0]       status,
  output logic [1:0]       halt_reason
);

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            r_state;
  reason_t           r_halt_reason;
  logic              r_gen_tick;
  logic              r_cell_load;
  logic [GRID-1:0]   r_init_pattern;
  logic [GEN_W-1:0]  r_generation;
  logic [GRID-1:0]   r_snapshot;
  logic              r_tick_d;

  state_t            w_state_n;
  reason_t           w_reason_n;
  logic              w_tick_n;
  logic              w_load_n;
  logic [GRID-1:0]   w_init_n;
  logic [GEN_W-1:0]  w_gen_n;
  logic [GRID-1:0]   w_snap_n;
  logic              w_tick_d_n;

  logic              w_adv;
  logic              w_halt_ext;
  logic              w_halt_stb;
  logic              w_halt;
  logic              w_div_en;
  logic              w_div_clr;
  logic              w_tc;

  // A tick without cell_load advances the array on this edge.
  assign w_adv      = r_gen_tick && !r_cell_load;

  // One cycle after an advance the board holds the new generation.
  assign w_halt_ext = r_tick_d && (board == '0);
  assign w_halt_stb = r_tick_d && (board != '0) && (board == r_snapshot);
  assign w_halt     = w_halt_ext || w_halt_stb;

  // The divider only runs while RUN is actually being held this cycle;
  // it restarts on a load and on every PAUSE -> RUN transition.
  assign w_div_en   = (r_state == ST_RUN) && run && !load_req && !w_halt;
  assign w_div_clr  = load_req || ((r_state == ST_PAUSE) && run && !w_halt);

  tick_divider #(
    .BASE_DIV (BASE_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (w_div_en),
    .clr   (w_div_clr),
    .speed (speed),
    .tc    (w_tc)
  );

  // Next-state decode: load beats halt, halt beats run/step.
  always_comb begin
    w_state_n  = r_state;
    w_reason_n = r_halt_reason;
    w_tick_n   = 1'b0;
    w_load_n   = 1'b0;
    w_init_n   = r_init_pattern;
    w_tick_d_n = w_adv;
    w_snap_n   = w_adv ? board : r_snapshot;
    w_gen_n    = w_adv ? sat_inc(r_generation) : r_generation;

    if (load_req) begin
      w_state_n  = ST_LOAD;
      w_reason_n = RSN_NONE;
      w_tick_n   = 1'b1;
      w_load_n   = 1'b1;
      w_init_n   = PATTERNS[pattern_sel];
      w_gen_n    = '0;
      w_tick_d_n = 1'b0;
    end else if (w_halt_ext) begin
      w_state_n  = ST_HALT;
      w_reason_n = RSN_EXTINCT;
    end else if (w_halt_stb) begin
      w_state_n  = ST_HALT;
      w_reason_n = RSN_STABLE;
    end else begin
      case (r_state)
        ST_LOAD: begin
          w_state_n = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (run) begin
            w_state_n = ST_RUN;
          end else if (step && !r_gen_tick) begin
            // A step arriving while its own tick is still on the output
            // is the same request and must not queue a second tick.
            w_tick_n = 1'b1;
          end
        end
        ST_RUN: begin
          if (!run) begin
            w_state_n = ST_PAUSE;
          end else begin
            w_tick_n = w_tc;
          end
        end
        default: begin
          // IDLE and HALT only leave on load_req.
        end
      endcase
    end
  end

  // Register every output and the halt-check history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_halt_reason  <= RSN_NONE;
      r_gen_tick     <= 1'b0;
      r_cell_load    <= 1'b0;
      r_init_pattern <= '0;
      r_generation   <= '0;
      r_snapshot     <= '0;
      r_tick_d       <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_halt_reason  <= w_reason_n;
      r_gen_tick     <= w_tick_n;
      r_cell_load    <= w_load_n;
      r_init_pattern <= w_init_n;
      r_generation   <= w_gen_n;
      r_snapshot     <= w_snap_n;
      r_tick_d       <= w_tick_d_n;
    end
  end

  assign gen_tick     = r_gen_tick;
  assign cell_load    = r_cell_load;
  assign init_pattern = r_init_pattern;
  assign generation   = r_generation;
  assign status       = r_state;
  assign halt_reason  = r_halt_reason;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with a behavioural 8x8 Life array
// (dead borders) closing the loop through board.
module tb_life_controller;

  localparam int BASE_DIV = 4;
  localparam int GEN_W    = 16;

  localparam logic [63:0] P_BLINK  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] P_GLIDER = 64'h0000_0000_0007_0402;
  localparam logic [63:0] P_BLOCK  = 64'h0000_0018_1800_0000;
  localparam logic [63:0] P_SINGLE = 64'h0000_0000_0000_0001;
  localparam logic [63:0] P_VBLINK = 64'h0000_0008_0808_0000;

  logic             clk;
  logic             reset;
  logic             load_req;
  logic [1:0]       pattern_sel;
  logic             run;
  logic             step;
  logic [2:0]       speed;
  logic [63:0]      board;
  logic             gen_tick;
  logic             cell_load;
  logic [63:0]      init_pattern;
  logic [GEN_W-1:0] generation;
  logic [2:0]       status;
  logic [1:0]       halt_reason;

  typedef struct {
    logic             cl;
    logic [63:0]      pat;
    logic [GEN_W-1:0] gen;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   n_ticks   = 0;
  int   last_tick = 0;
  int   prev_tick = 0;
  int   exp_gen   = 0;
  int   t_entry   = 0;

  life_controller #(
    .BASE_DIV (BASE_DIV),
    .GEN_W    (GEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .pattern_sel  (pattern_sel),
    .run          (run),
    .step         (step),
    .speed        (speed),
    .board        (board),
    .gen_tick     (gen_tick),
    .cell_load    (cell_load),
    .init_pattern (init_pattern),
    .generation   (generation),
    .status       (status),
    .halt_reason  (halt_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] n;
    int          cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              if (b[(r + dr) * 8 + c + dc]) cnt++;
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (cnt == 2 && b[r * 8 + c]);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] pat_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return P_BLINK;
      2'd1:    return P_GLIDER;
      2'd2:    return P_BLOCK;
      default: return P_SINGLE;
    endcase
  endfunction

  // Behavioural cell array.
  always @(posedge clk or negedge reset) begin
    if (!reset)        board <= '0;
    else if (gen_tick) board <= cell_load ? init_pattern : life_next(board);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic push_tick(input logic cl, input logic [63:0] pat, input int gen);
    exp_t e;
    e.cl  = cl;
    e.pat = pat;
    e.gen = GEN_W'(gen);
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit later, score any tick seen.
  task automatic clk1();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (gen_tick === 1'b1) begin
      prev_tick = last_tick;
      last_tick = cyc;
      n_ticks++;
      if (sb.size() == 0) begin
        check("unexpected_tick", 64'(sb.size() > 0), 64'(1));
      end else begin
        e = sb.pop_front();
        check("tick_cell_load", 64'(cell_load), 64'(e.cl));
        check("tick_generation", 64'(generation), 64'(e.gen));
        if (e.cl) check("tick_init_pattern", init_pattern, e.pat);
      end
    end
  endtask

  task automatic wait_tick(input int max_cyc);
    int n0;
    n0 = n_ticks;
    for (int i = 0; i < max_cyc && n_ticks == n0; i++) clk1();
    check("tick_arrived", 64'(n_ticks != n0), 64'(1));
  endtask

  task automatic do_load(input logic [1:0] sel);
    pattern_sel = sel;
    load_req    = 1'b1;
    push_tick(1'b1, pat_of(sel), 0);
    exp_gen = 0;
    clk1();
    load_req = 1'b0;
    check("load_status", 64'(status), 64'(3'd1));
    check("load_reason", 64'(halt_reason), 64'(2'd0));
    check("load_gen_tick", 64'(gen_tick), 64'(1'b1));
    clk1();
    check("post_load_status", 64'(status), 64'(3'd2));
    check("post_load_board", board, pat_of(sel));
    check("post_load_gen", 64'(generation), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    load_req    = 1'b0;
    pattern_sel = 2'd0;
    run         = 1'b0;
    step        = 1'b0;
    speed       = 3'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_status", 64'(status), 64'(3'd0));
    check("rst_gen_tick", 64'(gen_tick), 64'(1'b0));
    check("rst_cell_load", 64'(cell_load), 64'(1'b0));
    check("rst_init_pattern", init_pattern, 64'h0);
    check("rst_generation", 64'(generation), 64'(0));
    check("rst_reason", 64'(halt_reason), 64'(2'd0));
    clk1();
    clk1();
    reset = 1'b1;

    // IDLE ignores run and step.
    run  = 1'b1;
    step = 1'b1;
    repeat (3) clk1();
    check("idle_ignores_run", 64'(status), 64'(3'd0));
    run  = 1'b0;
    step = 1'b0;
    clk1();

    // Load blinker, free-run at speed 0.
    do_load(2'd0);
    speed = 3'd0;
    run   = 1'b1;
    clk1();
    t_entry = cyc;
    check("run_status", 64'(status), 64'(3'd3));
    for (int k = 1; k <= 4; k++) begin
      push_tick(1'b0, 64'h0, exp_gen);
      exp_gen++;
      wait_tick(3 * BASE_DIV);
      if (k == 1) check("first_tick_delay_s0", 64'(cyc - t_entry), 64'(BASE_DIV));
      else        check("tick_period_s0", 64'(last_tick - prev_tick), 64'(BASE_DIV));
      clk1();
      check("blink_generation", 64'(generation), 64'(k));
      check("blink_board", board, (k % 2 == 1) ? P_VBLINK : P_BLINK);
    end
    clk1();
    check("blink_still_running", 64'(status), 64'(3'd3));
    check("blink_reason", 64'(halt_reason), 64'(2'd0));
    run = 1'b0;
    clk1();
    check("pause_status", 64'(status), 64'(3'd2));

    // Block: one step halts STABLE.
    do_load(2'd2);
    push_tick(1'b0, 64'h0, exp_gen);
    exp_gen++;
    step = 1'b1;
    clk1();
    step = 1'b0;
    check("step_tick", 64'(gen_tick), 64'(1'b1));
    clk1();
    check("block_gen", 64'(generation), 64'(1));
    clk1();
    check("stable_status", 64'(status), 64'(3'd4));
    check("stable_reason", 64'(halt_reason), 64'(2'd2));
    check("stable_gen", 64'(generation), 64'(1));
    step = 1'b1;
    clk1();
    step = 1'b0;
    clk1();
    clk1();
    check("halt_ignores_step", 64'(status), 64'(3'd4));
    check("halt_gen_held", 64'(generation), 64'(1));

    // Single cell: one step halts EXTINCT, then reload clears the reason.
    do_load(2'd3);
    push_tick(1'b0, 64'h0, exp_gen);
    exp_gen++;
    step = 1'b1;
    clk1();
    step = 1'b0;
    clk1();
    clk1();
    check("extinct_status", 64'(status), 64'(3'd4));
    check("extinct_reason", 64'(halt_reason), 64'(2'd1));
    check("extinct_board", board, 64'h0);
    check("extinct_gen", 64'(generation), 64'(1));
    do_load(2'd2);

    // Speed 3: 16-clock period, drop run on an expiry cycle, resume.
    do_load(2'd0);
    speed = 3'd3;
    run   = 1'b1;
    clk1();
    t_entry = cyc;
    for (int k = 1; k <= 3; k++) begin
      push_tick(1'b0, 64'h0, exp_gen);
      exp_gen++;
      wait_tick(40);
      if (k == 1) check("first_tick_delay_s3", 64'(cyc - t_entry), 64'(16));
      else        check("tick_period_s3", 64'(last_tick - prev_tick), 64'(16));
    end
    repeat (15) clk1();
    run = 1'b0;
    clk1();
    check("drop_run_no_tick", 64'(gen_tick), 64'(1'b0));
    check("drop_run_status", 64'(status), 64'(3'd2));
    repeat (3) clk1();
    check("drop_run_gen", 64'(generation), 64'(exp_gen));
    run = 1'b1;
    clk1();
    t_entry = cyc;
    check("rerun_status", 64'(status), 64'(3'd3));
    push_tick(1'b0, 64'h0, exp_gen);
    exp_gen++;
    wait_tick(40);
    check("rerun_first_tick", 64'(cyc - t_entry), 64'(16));

    // Load lands on the expiry cycle: only the load tick fires.
    repeat (15) clk1();
    do_load(2'd1);
    clk1();
    check("glider_run_status", 64'(status), 64'(3'd3));
    clk1();

    // Asynchronous reset mid-RUN.
    #2 reset = 1'b0;
    #1;
    check("async_rst_status", 64'(status), 64'(3'd0));
    check("async_rst_gen_tick", 64'(gen_tick), 64'(1'b0));
    check("async_rst_cell_load", 64'(cell_load), 64'(1'b0));
    check("async_rst_pattern", init_pattern, 64'h0);
    check("async_rst_generation", 64'(generation), 64'(0));
    check("async_rst_reason", 64'(halt_reason), 64'(2'd0));
    clk1();
    clk1();
    check("held_rst_status", 64'(status), 64'(3'd0));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
